// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: FSM state type, counter-width helper and default parameters for serial_adder_n
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DIGIT = 1;
  function automatic int cnt_width(input int k);
    return (k <= 2) ? 1 : $clog2(k);
  endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder (a, b, ci -> s, co), purely combinational
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/serial_adder_n.sv
// serial_adder_n: digit-serial a+b+cin over WIDTH/DIGIT cycles; in_valid/in_ready operands a,b,cin; out_valid/out_ready results sum,cout,overflow
module serial_adder_n
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);
  localparam int K  = WIDTH / DIGIT;
  localparam int CW = cnt_width(K);
  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [DIGIT-1:0] s;
  logic [DIGIT:0]   c;
  if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad
    $error("serial_adder_n: WIDTH must be >= 2 and divisible by DIGIT");
  end
  assign c[0] = carry;
  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    full_adder_cell u_fa (.a(a_sr[i]), .b(b_sr[i]), .ci(c[i]), .s(s[i]), .co(c[i+1]));
  end
  assign in_ready  = state == IDLE && !rst;
  assign out_valid = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_sr     <= '0;
      b_sr     <= '0;
      sum      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= cin;
          cnt   <= '0;
          state <= RUN;
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          sum   <= (sum >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
          carry <= c[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(K - 1)) begin
            cout     <= c[DIGIT];
            overflow <= c[DIGIT-1] ^ c[DIGIT];
            state    <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_adder_n.sv
// tb_serial_adder_n: self-checking bench for serial_adder_n at (8,1), (8,4) and (3,1)
module tb_serial_adder_n;
  logic       clk = 1'b0;
  logic       rst;
  logic       iv[3], ordy[3], cin_[3];
  logic [7:0] aa[3], bb[3];
  logic       irdy[3], ov[3], co[3], of[3];
  logic [7:0] s0, s1;
  logic [2:0] s2;
  int checks = 0;
  int errors = 0;
  int ks[3] = '{8, 2, 3};
  int ws[3] = '{8, 8, 3};
  always #5 clk = ~clk;
  serial_adder_n #(.WIDTH(8), .DIGIT(1)) u0 (.clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .a(aa[0]), .b(bb[0]), .cin(cin_[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .sum(s0), .cout(co[0]), .overflow(of[0]));
  serial_adder_n #(.WIDTH(8), .DIGIT(4)) u1 (.clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .a(aa[1]), .b(bb[1]), .cin(cin_[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .sum(s1), .cout(co[1]), .overflow(of[1]));
  serial_adder_n #(.WIDTH(3), .DIGIT(1)) u2 (.clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
    .a(aa[2][2:0]), .b(bb[2][2:0]), .cin(cin_[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .sum(s2), .cout(co[2]), .overflow(of[2]));
  function automatic int sum_of(input int sel);
    return sel == 0 ? int'(s0) : sel == 1 ? int'(s1) : int'(s2);
  endfunction
  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic model(input int w, input int a, input int b, input int c, output int s, output int cy, output int o);
    int full, sa, sb, ss;
    full = a + b + c;
    s    = full % (1 << w);
    cy   = full / (1 << w);
    sa   = a >= (1 << (w - 1)) ? a - (1 << w) : a;
    sb   = b >= (1 << (w - 1)) ? b - (1 << w) : b;
    ss   = sa + sb + c;
    o    = (ss < -(1 << (w - 1)) || ss > (1 << (w - 1)) - 1) ? 1 : 0;
  endtask
  task automatic op(input int sel, input int a, input int b, input int c, input int stall,
                    input int es, input int ec, input int eo, input string tag);
    int n, lat, hs, hc, ho;
    n = 0;
    @(negedge clk);
    while (!irdy[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " in_ready idle"}, int'(irdy[sel]), 1);
    iv[sel] = 1'b1; aa[sel] = 8'(a); bb[sel] = 8'(b); cin_[sel] = c[0];
    @(posedge clk);
    #1;
    iv[sel] = 1'b0; aa[sel] = ~8'(a); bb[sel] = ~8'(b); cin_[sel] = ~c[0];
    lat = 0;
    while (!ov[sel] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, lat, ks[sel]);
    chk({tag, " sum"}, sum_of(sel), es);
    chk({tag, " cout"}, int'(co[sel]), ec);
    chk({tag, " overflow"}, int'(of[sel]), eo);
    chk({tag, " in_ready in DONE"}, int'(irdy[sel]), 0);
    hs = sum_of(sel); hc = int'(co[sel]); ho = int'(of[sel]);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk({tag, " stall hold"}, {sum_of(sel), hc[0], ho[0], ov[sel], irdy[sel]}, {hs, co[sel], of[sel], 2'b10});
    end
    ordy[sel] = 1'b1;
    @(posedge clk);
    #1;
    ordy[sel] = 1'b0;
    chk({tag, " out_valid drop"}, int'(ov[sel]), 0);
    chk({tag, " in_ready after"}, int'(irdy[sel]), 1);
  endtask
  typedef struct {int sel; int a; int b; int c; int stall; int es; int ec; int eo;} vec_t;
  vec_t tab[6];
  initial begin
    int es, ec, eo, bad;
    string tag;
    tab[0] = '{0, 'hFF, 'h01, 0, 0, 'h00, 1, 0};
    tab[1] = '{0, 'h7F, 'h01, 0, 0, 'h80, 0, 1};
    tab[2] = '{0, 'h80, 'h80, 1, 0, 'h01, 1, 1};
    tab[3] = '{1, 'h3C, 'h0F, 1, 5, 'h4C, 0, 0};
    tab[4] = '{1, 'hFF, 'hFF, 1, 0, 'hFF, 1, 0};
    tab[5] = '{2, 7, 7, 1, 2, 7, 1, 0};
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; ordy[i] = 1'b0; cin_[i] = 1'b0; aa[i] = '0; bb[i] = '0;
    end
    rst = 1'b1;
    iv[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset outputs %0d", i), {sum_of(i), co[i], of[i], ov[i], irdy[i]}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    iv[0] = 1'b0;
    #1;
    chk("in_ready after reset", {irdy[0], irdy[1], irdy[2]}, 3'b111);
    for (int i = 0; i < 6; i++) begin
      op(tab[i].sel, tab[i].a, tab[i].b, tab[i].c, tab[i].stall, tab[i].es, tab[i].ec, tab[i].eo,
         $sformatf("vec%0d", i));
    end
    @(negedge clk);
    iv[0] = 1'b1; aa[0] = 8'hAA; bb[0] = 8'h55; cin_[0] = 1'b0;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid-run reset outputs", {s0, co[0], of[0], ov[0], irdy[0]}, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ov[0]) bad++;
    end
    chk("no result after reset", bad, 0);
    op(0, 'h01, 'h02, 0, 0, 'h03, 0, 0, "post-reset");
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++) begin
          model(3, a, b, c, es, ec, eo);
          op(2, a, b, c, $urandom_range(0, 2), es, ec, eo, $sformatf("w3 %0d+%0d+%0d", a, b, c));
        end
    for (int i = 0; i < 40; i++) begin
      int sel, a, b, c;
      sel = i % 2; a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 1);
      model(ws[sel], a, b, c, es, ec, eo);
      tag = $sformatf("rnd%0d %0h+%0h+%0d", sel, a, b, c);
      op(sel, a, b, c, $urandom_range(0, 3), es, ec, eo, tag);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
